sbox_pipe: RTL
==============

Name: sbox_pipe

Overview:
- Parametrised, pipelined, multi-lane AES SubBytes engine.
- Successor to the single-byte combinational substitution table: LANES bytes per beat, configurable pipeline depth and valid/ready flow control.
- Optional inverse S-box mode for the decryption datapath.
- Sits between AddRoundKey/state register and ShiftRows in the round datapath; also usable by the key-expansion SubWord path with LANES=4.

Parameters:
- LANES, 16, number of byte lanes per beat (1..16); data width = 8*LANES.
- PIPE_STAGES, 2, register stages between input and output (1..3).
- TAG_W, 4, width of the sideband tag carried alongside data (>=1).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  8*LANES  input bytes; lane i = bits [8i+7:8i].
- in_inv  in  1  1 = inverse S-box for this beat (only honoured when SBOX_INV_EN is defined).
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  8*LANES  substituted bytes, lane-aligned with in_data.
- out_tag  out  TAG_W  tag of the beat on out_data.
- busy  out  1  any stage holds a valid beat.

Behaviour:
- Reset is asynchronous on rst_n low. It clears all stage valid bits. Outputs under reset: out_valid=0, out_data=0, out_tag=0, busy=0, in_ready=1.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Substitution:
  - Each lane is substituted independently: forward S(x) = affine(x^-1 in GF(2^8), poly 0x11B), with 0^-1 = 0.
  - Results are bit-exact to the FIPS-197 forward table, e.g. 00->63, 53->ED, FF->16.
  - Implementation method is free (logic inversion or ROM), provided results are exact.
- Pipeline structure:
  - PIPE_STAGES registers, each holding {valid, data, inv, tag}.
  - Stage k loads when it is empty or stage k+1 (or the output) is consuming this cycle.
  - Substitution logic may be split across stages. Output equals substitution of the captured input regardless of split.
- Latency and throughput:
  - Latency is exactly PIPE_STAGES cycles from input transfer to out_valid with out_ready held high.
  - Throughput is one beat per cycle when out_ready is continuously high.
- Ready logic:
  - in_ready = !stage0.valid || stage0 advancing this cycle; combinational from out_ready through the stage chain.
  - No beat is dropped or duplicated.
- Backpressure:
  - While out_valid && !out_ready, out_data and out_tag are held stable.
  - Once all stages are full, in_ready=0.
- Simultaneous events:
  - With the pipeline full and out_ready=1, a new input is accepted in the same cycle the output retires.
- Ordering: beats emerge strictly in acceptance order.
- busy = OR of all stage valid bits.
- Reset mid-operation: all in-flight beats are discarded. No partial output appears after rst_n deasserts.
- Parameter legality: PIPE_STAGES outside 1..3 or LANES outside 1..16 is a build-time error (generate-time check).

Optional Feature:
- Macro: SBOX_INV_EN.
- Defined: when a beat's in_inv=1, each lane gets the inverse S-box S^-1(y) = (affine^-1(y))^-1. Examples: 63->00, ED->53, 16->FF. in_inv travels with the beat, so forward and inverse beats may interleave back-to-back.
- Not defined: in_inv is ignored and all beats use the forward S-box; no inverse logic is synthesised. The port remains present for a uniform interface.

Test Plan:
- Reset, then LANES=16, PIPE_STAGES=2, single beat 193de3bea0f4e22b9ac68d2ae9f84808 (lane 15..0 as written) with out_ready=1 -> exactly 2 cycles later out_valid=1, out_data=d42711aee0bf98f1b8b45de51e415230.
- Exhaustive sweep: 256 beats, every lane = i for i in 0..255, streamed one per cycle -> every lane matches the FIPS-197 table (00->63, 01->7C, 52->00, FF->16), one output per cycle, tags in order.
- Backpressure: stream 6 beats with tags 1..6, out_ready low for cycles 3..7 -> in_ready drops once both stages are full; data and tag are held stable; outputs arrive with tags 1..6 in order, none lost or duplicated.
- With SBOX_INV_EN defined, interleave forward beat 00.. (inv=0) and inverse beat 63.. (inv=1) back-to-back -> outputs 63.. then 00..; repeat with the macro undefined -> both beats give forward results 63.. and FB...
- Assert rst_n low while 2 beats are in flight, release after 3 cycles -> out_valid=0, busy=0, in_ready=1; no stale beat appears afterwards.
- LANES=4, PIPE_STAGES=1: SubWord of 0xCF4F3C09 -> 0x8A84EB01 one cycle after acceptance.

Source files
------------

// File: rtl/sbox_pipe.sv
// Pipelined multi-lane AES SubBytes engine with valid/ready flow control.
// Define SBOX_INV_EN to honour in_inv (inverse S-box); otherwise all beats are forward.
module sbox_pipe #(
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int DW   = 8 * LANES;
    localparam int LAST = PIPE_STAGES - 1;

    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
            $error("sbox_pipe: PIPE_STAGES must be in 1..3");
        end
        if (LANES < 1 || LANES > 16) begin : g_bad_lanes
            $error("sbox_pipe: LANES must be in 1..16");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("sbox_pipe: TAG_W must be >= 1");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); conveniently maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x14  = gf_mul(x12, x2);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(x240, x14);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] a;
        a = gf_inv(x);
        return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
    endfunction

`ifdef SBOX_INV_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
    endfunction
`endif

    // Substitution is resolved before stage 0, so the inv flag need not travel further.
    logic [DW-1:0] sub_data;

    always_comb begin
        sub_data = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef SBOX_INV_EN
            sub_data[8*i +: 8] = in_inv ? inv_sbox(in_data[8*i +: 8])
                                        : fwd_sbox(in_data[8*i +: 8]);
`else
            sub_data[8*i +: 8] = fwd_sbox(in_data[8*i +: 8]);
`endif
        end
    end

`ifndef SBOX_INV_EN
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    logic [PIPE_STAGES-1:0] vld_q;
    logic [DW-1:0]          data_q [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] load;

    // A stage may load when empty or when everything downstream of it moves.
    always_comb begin
        load       = '0;
        load[LAST] = !vld_q[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            load[k] = !vld_q[k] || load[k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            if (load[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= sub_data;
                    tag_q[0]  <= in_tag;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (load[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                        tag_q[k]  <= tag_q[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_tag   = tag_q[LAST];
    assign busy      = |vld_q;

endmodule
